// File: rtl/exec_pkg.sv
// Shared types and default geometry for the vector execute stage.
package exec_pkg;
    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] { IDLE, VEC, HOLD } exec_state_e;
endpackage

// File: rtl/lane_alu.sv
// One lane of the vector ALU; add/sub optionally saturate as signed values.
module lane_alu
    import exec_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  alu_op_e           op,
    input  logic              satEn,
    output logic [LANE_W-1:0] y
);
    localparam int SHW = $clog2(LANE_W);

    logic [LANE_W-1:0] sum, diff, satVal;
    logic              sumOvf, diffOvf;

    assign sum     = a + b;
    assign diff    = a - b;
    assign sumOvf  = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
    assign diffOvf = (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
    // Signed overflow always runs past the extreme on a's side of zero.
    assign satVal  = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = (satEn && sumOvf) ? satVal : sum;
            ALU_SUB: y = (satEn && diffOvf) ? satVal : diff;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(LANE_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: y = a << b[SHW-1:0];
            default: y = a >> b[SHW-1:0];
        endcase
    end
endmodule

// File: rtl/vec_execute_unit.sv
// Execute stage: scalar ops in one cycle, vector ops PAR lanes per cycle.
// Define VEC_SAT_EN to make vector add/sub saturate per lane.
module vec_execute_unit
    import exec_pkg::*;
#(
    parameter  int LANES  = DEF_LANES,
    parameter  int LANE_W = DEF_LANE_W,
    parameter  int PAR    = 1,
    localparam int VW     = LANES * LANE_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          is_vectorial,
    input  logic          alu_src,
    input  logic          reg_write,
    input  logic          mem_write,
    input  logic          result_src,
    input  logic          branch,
    input  logic [2:0]    alu_ctrl,
    input  logic [VW-1:0] rd1,
    input  logic [VW-1:0] rd2,
    input  logic [VW-1:0] result_w,
    input  logic [31:0]   imm,
    input  logic [31:0]   pc,
    input  logic [31:0]   pc_plus4,
    input  logic [5:0]    rd_addr,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] alu_result_m,
    output logic [VW-1:0] write_data_m,
    output logic [5:0]    rd_m,
    output logic [31:0]   pc_plus4_m,
    output logic          reg_write_m,
    output logic          mem_write_m,
    output logic          result_src_m,
    output logic          pc_src,
    output logic [31:0]   pc_target,
    output logic          busy
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    exec_state_e state, stateNext;
    logic [CW-1:0] laneCnt;
    vec_t fwdA, fwdB, opBLive, opA, opB, res;
    alu_op_e opReg, aluOp;
    logic aluSat, accept, lastStep;
    logic [LANE_W-1:0] immLane;
    logic [PAR-1:0][LANE_W-1:0] aluA, aluB, aluY;

    always_comb begin
        fwdA = rd1;
        case (fwd_sel_e'(fwd_a))
            FWD_WB:  fwdA = result_w;
            FWD_MEM: fwdA = res;
            default: fwdA = rd1;
        endcase
    end

    always_comb begin
        fwdB = rd2;
        case (fwd_sel_e'(fwd_b))
            FWD_WB:  fwdB = result_w;
            FWD_MEM: fwdB = res;
            default: fwdB = rd2;
        endcase
    end

    assign immLane = LANE_W'($signed(imm));
    for (genvar l = 0; l < LANES; l++) begin : gOpB
        assign opBLive[l] = alu_src ? immLane : fwdB[l];
    end

    assign in_ready  = rst && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign lastStep  = (laneCnt == CW'(LANES - PAR));
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign pc_target = pc + imm;
    assign pc_src    = accept && branch && !is_vectorial && (fwdA[0] == fwdB[0]);
    assign alu_result_m = res;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = is_vectorial ? VEC : HOLD;
            VEC:  if (lastStep) stateNext = HOLD;
            HOLD: begin
                if (accept)         stateNext = is_vectorial ? VEC : HOLD;
                else if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outside VEC the ALUs see live operands so a scalar result lands on the accept edge.
    assign aluOp = (state == VEC) ? opReg : alu_op_e'(alu_ctrl);
`ifdef VEC_SAT_EN
    assign aluSat = (state == VEC);
`else
    assign aluSat = 1'b0;
`endif

    for (genvar i = 0; i < PAR; i++) begin : gLane
        logic [CW-1:0] idx;
        assign idx     = laneCnt + CW'(i);
        assign aluA[i] = (state == VEC) ? opA[idx] : fwdA[i];
        assign aluB[i] = (state == VEC) ? opB[idx] : opBLive[i];
        lane_alu #(.LANE_W(LANE_W)) uAlu (
            .a(aluA[i]), .b(aluB[i]), .op(aluOp), .satEn(aluSat), .y(aluY[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            laneCnt      <= '0;
            opA          <= '0;
            opB          <= '0;
            opReg        <= ALU_ADD;
            res          <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            pc_plus4_m   <= '0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opA          <= fwdA;
                opB          <= opBLive;
                opReg        <= alu_op_e'(alu_ctrl);
                write_data_m <= fwdB;
                rd_m         <= rd_addr;
                pc_plus4_m   <= pc_plus4;
                reg_write_m  <= reg_write;
                mem_write_m  <= mem_write;
                result_src_m <= result_src;
                laneCnt      <= '0;
                res          <= '0;
                if (!is_vectorial) res[0] <= aluY[0];
            end else if (state == VEC) begin
                for (int i = 0; i < PAR; i++) res[laneCnt + CW'(i)] <= aluY[i];
                laneCnt <= laneCnt + CW'(PAR);
            end
        end
    end
endmodule

// File: tb/tb_vec_execute_unit.sv
// Self-checking bench for vec_execute_unit against a plain-arithmetic lane model.
module tb_vec_execute_unit;
    localparam int LANES = 4, LANE_W = 32, PAR = 1, VW = LANES * LANE_W;
`ifdef VEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid, in_ready, is_vectorial, alu_src, reg_write, mem_write, result_src, branch;
    logic [2:0] alu_ctrl;
    logic [VW-1:0] rd1, rd2, result_w, alu_result_m, write_data_m;
    logic [31:0] imm, pc, pc_plus4, pc_plus4_m, pc_target;
    logic [5:0] rd_addr, rd_m;
    logic [1:0] fwd_a, fwd_b;
    logic out_valid, out_ready, reg_write_m, mem_write_m, result_src_m, pc_src, busy;
    int tests = 0, fails = 0;
    logic [VW-1:0] lastRes = '0;

    always #5 clk = ~clk;

    vec_execute_unit #(.LANES(LANES), .LANE_W(LANE_W), .PAR(PAR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_vectorial(is_vectorial), .alu_src(alu_src), .reg_write(reg_write),
        .mem_write(mem_write), .result_src(result_src), .branch(branch),
        .alu_ctrl(alu_ctrl), .rd1(rd1), .rd2(rd2), .result_w(result_w),
        .imm(imm), .pc(pc), .pc_plus4(pc_plus4), .rd_addr(rd_addr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .pc_src(pc_src), .pc_target(pc_target), .busy(busy)
    );

    function automatic logic [31:0] refLane(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input bit sat);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
        if (sat && r > SMAX) r = SMAX;
        if (sat && r < SMIN) r = SMIN;
        return r[31:0];
    endfunction

    function automatic logic [VW-1:0] refOp(input bit vec, input logic [2:0] op,
            input logic [VW-1:0] a, input logic [VW-1:0] b, input bit src, input logic [31:0] im);
        logic [VW-1:0] r;
        logic [31:0] bl;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            bl = src ? im : b[l*32 +: 32];
            if (vec || l == 0) r[l*32 +: 32] = refLane(a[l*32 +: 32], bl, op, vec && SAT && op <= 3'd1);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] pick(input logic [1:0] s, input logic [VW-1:0] r,
                                           input logic [VW-1:0] w, input logic [VW-1:0] m);
        return (s == 2'b01) ? w : (s == 2'b10) ? m : r;
    endfunction

    task automatic clearIn();
        in_valid = 0; is_vectorial = 0; alu_src = 0; reg_write = 0; mem_write = 0;
        result_src = 0; branch = 0; alu_ctrl = 0; rd1 = '0; rd2 = '0; result_w = '0;
        imm = 0; pc = 0; pc_plus4 = 0; rd_addr = 0; fwd_a = 0; fwd_b = 0; out_ready = 0;
    endtask

    task automatic issue(input bit vec, input logic [2:0] op, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input bit src, input logic [31:0] im);
        in_valid = 1; is_vectorial = vec; alu_ctrl = op; rd1 = a; rd2 = b; alu_src = src; imm = im;
    endtask

    task automatic waitValid(output int cyc, output bit to);
        cyc = 0; to = 0;
        while (out_valid !== 1'b1) begin
            if (cyc >= 40) begin to = 1; return; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset();
        clearIn();
        #2 rst = 0;
        in_valid = 1;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_state got v%b b%b want 0 0", out_valid, busy); end
        in_valid = 0; rst = 1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        tests++; if (alu_result_m !== '0 || rd_m !== 6'd0 || pc_plus4_m !== 32'd0) begin fails++; $display("FAIL rst_outputs got %h %h %h want 0", alu_result_m, rd_m, pc_plus4_m); end
        lastRes = '0;
    endtask

    task automatic test_scalar_add();
        @(negedge clk); clearIn();
        issue(0, 3'd0, VW'(10), VW'(20), 0, 0); rd_addr = 6'd5; reg_write = 1; pc_plus4 = 32'h44;
        @(negedge clk); in_valid = 0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sc_valid got %b want 1", out_valid); end
        tests++; if (alu_result_m !== VW'(30)) begin fails++; $display("FAIL sc_result got %h want %h", alu_result_m, VW'(30)); end
        tests++; if (rd_m !== 6'd5 || reg_write_m !== 1'b1 || pc_plus4_m !== 32'h44 || busy !== 1'b1) begin fails++; $display("FAIL sc_ctrl got %h %b %h %b", rd_m, reg_write_m, pc_plus4_m, busy); end
        out_ready = 1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sc_retire got v%b b%b want 0 0", out_valid, busy); end
        lastRes = VW'(30);
    endtask

    task automatic test_vector_add();
        int cyc; bit to;
        logic [VW-1:0] want;
        want = {32'd12, 32'd11, 32'd10, 32'd9};
        @(negedge clk); clearIn();
        issue(1, 3'd0, {4{32'd8}}, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0);
        @(negedge clk); in_valid = 0;
        for (int c = 0; c < LANES / PAR; c++) begin
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL vec_busy_cyc%0d got r%b v%b want 0 0", c, in_ready, out_valid); end
            @(negedge clk);
        end
        waitValid(cyc, to);
        tests++; if (to || cyc != 0) begin fails++; $display("FAIL vec_latency got extra %0d timeout %b want 0", cyc, to); end
        tests++; if (alu_result_m !== want) begin fails++; $display("FAIL vec_result got %h want %h", alu_result_m, want); end
        out_ready = 1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL vec_busy_end got %b want 0", busy); end
        lastRes = want;
    endtask

    task automatic test_forwarding();
        @(negedge clk); clearIn();
        issue(0, 3'd0, VW'(10), VW'(20), 0, 0);
        @(negedge clk);
        issue(0, 3'd1, VW'(999), VW'(5), 0, 0); fwd_a = 2'b10; out_ready = 1;
        @(negedge clk);
        tests++; if (alu_result_m !== VW'(25) || out_valid !== 1'b1) begin fails++; $display("FAIL fwd_mem got %h v%b want 25", alu_result_m, out_valid); end
        issue(0, 3'd0, VW'(0), VW'(99), 0, 0); fwd_a = 2'b00; fwd_b = 2'b01; result_w = VW'(7);
        @(negedge clk); in_valid = 0;
        tests++; if (alu_result_m !== VW'(7) || write_data_m !== VW'(7)) begin fails++; $display("FAIL fwd_wb got %h wd %h want 7 7", alu_result_m, write_data_m); end
        @(negedge clk);
        lastRes = VW'(7);
    endtask

    task automatic test_branch();
        int cyc; bit to;
        @(negedge clk); clearIn();
        issue(0, 3'd1, VW'(9), VW'(9), 0, 32'd16); branch = 1; pc = 32'd100;
        #1;
        tests++; if (pc_src !== 1'b1 || pc_target !== 32'd116) begin fails++; $display("FAIL br_scalar got %b %0d want 1 116", pc_src, pc_target); end
        @(negedge clk); in_valid = 0;
        #1;
        tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL br_noaccept got %b want 0", pc_src); end
        out_ready = 1;
        @(negedge clk);
        issue(1, 3'd1, VW'(9), VW'(9), 0, 32'd16);
        #1;
        tests++; if (pc_src !== 1'b0 || pc_target !== 32'd116) begin fails++; $display("FAIL br_vector got %b %0d want 0 116", pc_src, pc_target); end
        @(negedge clk); in_valid = 0; branch = 0; out_ready = 0;
        waitValid(cyc, to);
        tests++; if (to) begin fails++; $display("FAIL br_vec_done timeout got 1 want 0"); end
        lastRes = '0;
        out_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_sat_hold();
        int cyc; bit to;
        logic [VW-1:0] a, b, want;
        @(negedge clk); clearIn();
        issue(0, 3'd0, VW'(32'h7FFFFFFF), VW'(1), 0, 0);
        @(negedge clk); in_valid = 0;
        tests++; if (alu_result_m !== VW'(32'h80000000)) begin fails++; $display("FAIL sat_scalar got %h want 80000000", alu_result_m); end
        out_ready = 1;
        @(negedge clk);
        a = {32'd5, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        b = {32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd1};
        want = refOp(1, 3'd0, a, b, 0, 0);
        issue(1, 3'd0, a, b, 0, 0); out_ready = 0;
        @(negedge clk); in_valid = 0;
        waitValid(cyc, to);
        tests++; if (to || alu_result_m[31:0] !== (SAT ? 32'h7FFFFFFF : 32'h80000000)) begin fails++; $display("FAIL sat_lane0 got %h want %h", alu_result_m[31:0], SAT ? 32'h7FFFFFFF : 32'h80000000); end
        for (int c = 0; c < 3; c++) begin
            tests++; if (out_valid !== 1'b1 || alu_result_m !== want) begin fails++; $display("FAIL hold_cyc%0d got v%b %h want %h", c, out_valid, alu_result_m, want); end
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        lastRes = want;
    endtask

    task automatic test_reset_mid_vec();
        int cyc; bit to;
        @(negedge clk); clearIn();
        issue(1, 3'd0, {4{32'd3}}, {4{32'd4}}, 0, 0); rd_addr = 6'd9; pc_plus4 = 32'h80;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_state got v%b b%b r%b want 0 0 0", out_valid, busy, in_ready); end
        tests++; if (alu_result_m !== '0 || rd_m !== 6'd0 || pc_plus4_m !== 32'd0) begin fails++; $display("FAIL mid_rst_outputs got %h %h %h want 0", alu_result_m, rd_m, pc_plus4_m); end
        @(negedge clk); rst = 1; lastRes = '0;
        issue(0, 3'd2, VW'(32'hF0F0), VW'(32'hFF00), 0, 0);
        @(negedge clk); in_valid = 0;
        waitValid(cyc, to);
        tests++; if (to || alu_result_m !== VW'(32'hF000)) begin fails++; $display("FAIL post_rst_op got %h want f000", alu_result_m); end
        lastRes = VW'(32'hF000);
        out_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_random();
        int cyc; bit to, vec, src, br, wantPc;
        logic [2:0] op;
        logic [1:0] fa, fb;
        logic [VW-1:0] a, b, w, ea, eb, want;
        logic [31:0] im;
        logic [5:0] rda;
        @(negedge clk); clearIn();
        for (int k = 0; k < 40; k++) begin
            vec = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b[31:0] = a[31:0];
            w = {$urandom, $urandom, $urandom, $urandom};
            src = $urandom_range(0, 1);
            im = $urandom;
            br = $urandom_range(0, 1);
            fa = (k == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            fb = (k == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            rda = 6'($urandom);
            ea = pick(fa, a, w, lastRes);
            eb = pick(fb, b, w, lastRes);
            want = refOp(vec, op, ea, eb, src, im);
            wantPc = br && !vec && (ea[31:0] == eb[31:0]);
            issue(vec, op, a, b, src, im);
            fwd_a = fa; fwd_b = fb; result_w = w; branch = br; rd_addr = rda; out_ready = 1;
            #1;
            tests++; if (in_ready !== 1'b1 || pc_src !== 1'(wantPc)) begin fails++; $display("FAIL rnd%0d_issue got r%b pc%b want 1 %0d", k, in_ready, pc_src, wantPc); end
            @(negedge clk); in_valid = 0; out_ready = 0; branch = 0;
            waitValid(cyc, to);
            tests++; if (to || cyc != (vec ? LANES / PAR : 0)) begin fails++; $display("FAIL rnd%0d_latency got %0d timeout %b want %0d", k, cyc, to, vec ? LANES / PAR : 0); end
            tests++; if (alu_result_m !== want) begin fails++; $display("FAIL rnd%0d_result op%0d vec%0d got %h want %h", k, op, vec, alu_result_m, want); end
            tests++; if (write_data_m !== eb || rd_m !== rda) begin fails++; $display("FAIL rnd%0d_wd got %h rd %h want %h %h", k, write_data_m, rd_m, eb, rda); end
            lastRes = want;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd_drain got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_scalar_add();
        test_vector_add();
        test_forwarding();
        test_branch();
        test_sat_hold();
        test_reset_mid_vec();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
